regfile_mp: RTL and testbench

Parametrised multi-port register file for the Y86 core: two combinational read ports (A, B), two clocked write ports (E from execute, M from memory) with same-cycle write-to-read bypass, and a per-register busy scoreboard so decode can detect read-after-write hazards. It sits in the decode stage. It is the successor to the fixed 8×32 read-only register file, adding writes, reset values, forwarding and hazard tracking.

---
 rtl/regfile_mp_pkg.sv | 23 ++
 rtl/regfile_mp_scoreboard.sv | 44 ++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared Y86 register-file constants: register IDs, the "no register" ID and datapath ranges.
package regfile_mp_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned REGNUM = 8;

    localparam logic [ID_W-1:0] NOREG = '1;

    localparam int unsigned WORD_MSB = 31;
    localparam int unsigned WORD_LSB = 0;
    localparam int unsigned BYTE_MSB = 7;
    localparam int unsigned BYTE_LSB = 0;

    localparam logic [ID_W-1:0] EAX = 4'h0;
    localparam logic [ID_W-1:0] ECX = 4'h1;
    localparam logic [ID_W-1:0] EDX = 4'h2;
    localparam logic [ID_W-1:0] EBX = 4'h3;
    localparam logic [ID_W-1:0] ESP = 4'h4;
    localparam logic [ID_W-1:0] EBP = 4'h5;
    localparam logic [ID_W-1:0] ESI = 4'h6;
    localparam logic [ID_W-1:0] EDI = 4'h7;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits for read-after-write hazard detection in decode.
module regfile_scoreboard #(
    parameter int unsigned REGNUM = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             claim_v,
    input  logic [IDX_W-1:0] claim_idx,
    input  logic             e_v,
    input  logic [IDX_W-1:0] e_idx,
    input  logic             m_v,
    input  logic [IDX_W-1:0] m_idx,
    input  logic             a_v,
    input  logic [IDX_W-1:0] a_idx,
    input  logic             b_v,
    input  logic [IDX_W-1:0] b_idx,
    output logic             busyA,
    output logic             busyB
);

    logic [REGNUM-1:0] busy;
    logic [REGNUM-1:0] written;
    logic [REGNUM-1:0] claimed;

    always_comb begin
        written = '0;
        claimed = '0;
        if (e_v)     written[e_idx]     = 1'b1;
        if (m_v)     written[m_idx]     = 1'b1;
        if (claim_v) claimed[claim_idx] = 1'b1;
    end

    // A claim in the same cycle as a write leaves the bit set: the new producer wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~written) | claimed;
    end

    // A register being written this cycle is served by the bypass, so it is not busy.
    assign busyA = a_v & busy[a_idx] & ~written[a_idx];
    assign busyB = b_v & busy[b_idx] & ~written[b_idx];

endmodule

// File: rtl/regfile_mp.sv
// Y86 decode-stage register file: two bypassed read ports, E/M write ports, busy scoreboard.
module regfile_mp #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       REGNUM  = regfile_mp_pkg::REGNUM,
    parameter int unsigned       ID_W    = regfile_mp_pkg::ID_W,
    parameter int unsigned       SP_IDX  = 32'(regfile_mp_pkg::ESP),
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0000_0100)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   srcA,
    input  logic [ID_W-1:0]   srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              busyA,
    output logic              busyB,
    input  logic [ID_W-1:0]   dstE,
    input  logic [ID_W-1:0]   dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [ID_W-1:0]   claim_id,
    output logic              bad_id
);

    localparam int unsigned     IDX_W    = (REGNUM > 1) ? $clog2(REGNUM) : 1;
    localparam logic [ID_W-1:0] NOREG_ID = '1;

    function automatic logic in_range(input logic [ID_W-1:0] id);
        return (id != NOREG_ID) && (32'(id) < REGNUM);
    endfunction

    function automatic logic is_bad(input logic [ID_W-1:0] id);
        return (id != NOREG_ID) && (32'(id) >= REGNUM);
    endfunction

    logic             a_v, b_v, e_v, m_v, c_v;
    logic [IDX_W-1:0] a_idx, b_idx, e_idx, m_idx, c_idx;
    logic [DATA_W-1:0] regs [REGNUM];

    // Writes and claims are suppressed while reset is held.
    assign a_v = in_range(srcA);
    assign b_v = in_range(srcB);
    assign e_v = in_range(dstE) & ~rst;
    assign m_v = in_range(dstM) & ~rst;
    assign c_v = in_range(claim_id) & ~rst;

    assign a_idx = IDX_W'(srcA);
    assign b_idx = IDX_W'(srcB);
    assign e_idx = IDX_W'(dstE);
    assign m_idx = IDX_W'(dstM);
    assign c_idx = IDX_W'(claim_id);

    // M is applied after E so it wins a same-register conflict (popl %esp).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REGNUM; i++)
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
        end else begin
            if (e_v) regs[e_idx] <= valE;
            if (m_v) regs[m_idx] <= valM;
        end
    end

    assign valA = !a_v                     ? '0   :
                  (m_v && (m_idx == a_idx)) ? valM :
                  (e_v && (e_idx == a_idx)) ? valE : regs[a_idx];

    assign valB = !b_v                     ? '0   :
                  (m_v && (m_idx == b_idx)) ? valM :
                  (e_v && (e_idx == b_idx)) ? valE : regs[b_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bad_id <= 1'b0;
        else if (is_bad(srcA) || is_bad(srcB) || is_bad(dstE) || is_bad(dstM) || is_bad(claim_id))
            bad_id <= 1'b1;
    end

    regfile_scoreboard #(
        .REGNUM (REGNUM),
        .IDX_W  (IDX_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .claim_v   (c_v),
        .claim_idx (c_idx),
        .e_v       (e_v),
        .e_idx     (e_idx),
        .m_v       (m_v),
        .m_idx     (m_idx),
        .a_v       (a_v),
        .a_idx     (a_idx),
        .b_v       (b_v),
        .b_idx     (b_idx),
        .busyA     (busyA),
        .busyB     (busyB)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp against an array/bit-vector reference model.
module tb_regfile_mp;

    localparam logic [3:0] NO = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  srcA, srcB, dstE, dstM, claim_id;
    logic [31:0] valA, valB, valE, valM;
    logic        busyA, busyB, bad_id;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [31:0] mregs [8];
    bit          mbusy [8];
    bit          mbad;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .busyA(busyA), .busyB(busyB),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .claim_id(claim_id), .bad_id(bad_id)
    );

    function automatic bit inr(input logic [3:0] id);
        return id < 4'd8;
    endfunction

    function automatic bit isbad(input logic [3:0] id);
        return (id >= 4'd8) && (id != NO);
    endfunction

    function automatic logic [31:0] exp_val(input logic [3:0] s);
        logic [2:0] k;
        k = s[2:0];
        if (!inr(s))              return 32'd0;
        if (!rst && (dstM == s))  return valM;
        if (!rst && (dstE == s))  return valE;
        return mregs[k];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [3:0] s);
        logic [2:0] k;
        k = s[2:0];
        if (!inr(s) || rst) return 32'd0;
        if ((dstE == s) || (dstM == s)) return 32'd0;
        return {31'd0, mbusy[k]};
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 8; i++) begin
            mregs[i] = (i == 4) ? 32'h0000_0100 : 32'd0;
            mbusy[i] = 1'b0;
        end
        mbad = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            reset_model();
        end else begin
            if (inr(dstE)) begin mregs[dstE[2:0]] = valE; mbusy[dstE[2:0]] = 1'b0; end
            if (inr(dstM)) begin mregs[dstM[2:0]] = valM; mbusy[dstM[2:0]] = 1'b0; end
            if (inr(claim_id)) mbusy[claim_id[2:0]] = 1'b1;
            if (isbad(srcA) || isbad(srcB) || isbad(dstE) || isbad(dstM) || isbad(claim_id))
                mbad = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valA",   valA,            exp_val(srcA));
        chk("valB",   valB,            exp_val(srcB));
        chk("busyA",  {31'd0, busyA},  exp_busy(srcA));
        chk("busyB",  {31'd0, busyB},  exp_busy(srcB));
        chk("bad_id", {31'd0, bad_id}, {31'd0, mbad});
    endtask

    task automatic drive(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] de,
                         input logic [3:0] dm, input logic [31:0] ve, input logic [31:0] vm,
                         input logic [3:0] cl);
        srcA = sa; srcB = sb; dstE = de; dstM = dm; valE = ve; valM = vm; claim_id = cl;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic edge_update();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        settle();
        check_all();
        edge_update();
    endtask

    function automatic logic [3:0] pick();
        int r;
        r = $urandom_range(0, 9);
        return (r < 8) ? 4'(r) : NO;
    endfunction

    initial begin
        rst = 1'b1;
        drive(NO, NO, NO, NO, 32'd0, 32'd0, NO);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset contents of every register
        for (int i = 0; i < 8; i++) begin
            drive(4'(i), 4'(7 - i), NO, NO, 32'd0, 32'd0, NO);
            settle();
            chk("rst_reg", valA, (i == 4) ? 32'h0000_0100 : 32'd0);
            check_all();
            edge_update();
        end

        // Same-cycle bypass, then array read
        drive(4'd2, NO, 4'd2, NO, 32'hDEAD_BEEF, 32'd0, NO);
        settle(); chk("byp_E", valA, 32'hDEAD_BEEF); check_all(); edge_update();
        drive(4'd2, NO, NO, NO, 32'd0, 32'd0, NO);
        settle(); chk("arr_E", valA, 32'hDEAD_BEEF); check_all(); edge_update();

        // E/M conflict: M wins
        drive(NO, 4'd4, 4'd4, 4'd4, 32'd5, 32'd9, NO);
        settle(); chk("conf_byp", valB, 32'd9); check_all(); edge_update();
        drive(NO, 4'd4, NO, NO, 32'd0, 32'd0, NO);
        settle(); chk("conf_arr", valB, 32'd9); check_all(); edge_update();

        // Scoreboard set / clear / same-cycle claim+write
        drive(4'd3, NO, NO, NO, 32'd0, 32'd0, 4'd3);
        step();
        drive(4'd3, NO, NO, NO, 32'd0, 32'd0, NO);
        settle(); chk("sb_set1", {31'd0, busyA}, 32'd1); check_all(); edge_update();
        settle(); chk("sb_set2", {31'd0, busyA}, 32'd1); check_all(); edge_update();
        drive(4'd3, NO, NO, 4'd3, 32'd0, 32'd77, NO);
        settle(); chk("sb_byp", {31'd0, busyA}, 32'd0); check_all(); edge_update();
        drive(4'd3, NO, NO, NO, 32'd0, 32'd0, NO);
        settle(); chk("sb_clr", {31'd0, busyA}, 32'd0); check_all(); edge_update();
        drive(4'd3, NO, 4'd3, NO, 32'd11, 32'd0, 4'd3);
        step();
        drive(4'd3, NO, NO, NO, 32'd0, 32'd0, NO);
        settle(); chk("sb_reclaim", {31'd0, busyA}, 32'd1); check_all(); edge_update();

        // NOREG on all write/claim ports
        for (int k = 0; k < 10; k++) begin
            drive(4'(k % 8), 4'((k + 3) % 8), NO, NO, $urandom, $urandom, NO);
            step();
        end

        // Randomized traffic with in-range or NOREG IDs
        for (int k = 0; k < 300; k++) begin
            drive(pick(), pick(), pick(), pick(), $urandom, $urandom, pick());
            step();
        end

        // Out-of-range IDs
        drive(4'd9, NO, NO, NO, 32'd0, 32'd0, NO);
        settle();
        chk("oor_val",  valA, 32'd0);
        chk("oor_busy", {31'd0, busyA}, 32'd0);
        chk("oor_bad0", {31'd0, bad_id}, 32'd0);
        edge_update();
        drive(NO, NO, 4'd9, NO, 32'h1234_5678, 32'd0, NO);
        settle(); chk("oor_bad1", {31'd0, bad_id}, 32'd1); check_all(); edge_update();
        for (int i = 0; i < 8; i++) begin
            drive(4'(i), 4'(7 - i), NO, NO, 32'd0, 32'd0, NO);
            step();
        end
        chk("oor_sticky", {31'd0, bad_id}, 32'd1);

        // Asynchronous reset in the middle of a write/claim cycle
        drive(4'd4, 4'd2, 4'd2, 4'd4, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 4'd2);
        #2;
        rst = 1'b1;
        reset_model();
        #1;
        chk("arst_sp",  valA, 32'h0000_0100);
        chk("arst_r2",  valB, 32'd0);
        chk("arst_bad", {31'd0, bad_id}, 32'd0);
        check_all();
        edge_update();
        step();
        rst = 1'b0;
        drive(NO, NO, NO, NO, 32'd0, 32'd0, NO);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(4'(i), 4'(7 - i), NO, NO, 32'd0, 32'd0, NO);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
